// File: rtl/mem_responder.sv
// Single-port word memory responder for the multi-cycle processor.
// One request at a time, configurable wait states, registered ready/err/rdata.
module mem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT      = 4'(LATENCY);
   localparam logic       ZERO_LAT = (LATENCY == 0);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        weReq_q;
   logic [31:0] addrReq_q;
   logic [31:0] wdataReq_q;
   logic        errPend_q;
   logic [31:0] rdata_q;
   logic        ready_q;
   logic        err_q;
   logic [31:0] mem [DEPTH];

   logic                  accEn_d;
   logic                  accWe_d;
   logic                  accValid_d;
   logic [31:0]           accAddr_d;
   logic [31:0]           accWdata_d;
   logic [DEPTH_LOG2-1:0] accIdx_d;

   // With zero latency the access happens on the accepting edge, so it must use the live inputs.
   always_comb begin
      accAddr_d  = addrReq_q;
      accWdata_d = wdataReq_q;
      accWe_d    = weReq_q;
      accEn_d    = 1'b0;
      if (state_q == IDLE) begin
         accAddr_d  = addr;
         accWdata_d = wdata;
         accWe_d    = we;
         accEn_d    = ZERO_LAT && req;
      end else if (state_q == BUSY) begin
         accEn_d = (cnt_q == 4'd1);
      end
      accValid_d = (accAddr_d[1:0] == 2'b00) && (accAddr_d[31:DEPTH_LOG2+2] == '0);
      accIdx_d   = accAddr_d[DEPTH_LOG2+1:2];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         weReq_q    <= 1'b0;
         addrReq_q  <= 32'd0;
         wdataReq_q <= 32'd0;
         errPend_q  <= 1'b0;
         rdata_q    <= 32'd0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         if (accEn_d) begin
            errPend_q <= !accValid_d;
            if (!accWe_d) begin
               rdata_q <= accValid_d ? mem[accIdx_d] : 32'd0;
            end
         end
         case (state_q)
            IDLE: begin
               if (req) begin
                  weReq_q    <= we;
                  addrReq_q  <= addr;
                  wdataReq_q <= wdata;
                  cnt_q      <= LAT;
                  if (ZERO_LAT) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               ready_q <= 1'b1;
               err_q   <= errPend_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Array contents survive reset; a reset on the access edge drops the write.
   always_ff @(posedge clk) begin
      if (!reset && accEn_d && accWe_d && accValid_d) begin
         mem[accIdx_d] <= accWdata_d;
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance and a LATENCY=0 instance share one request bus.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata2, rdata0;
   logic        ready2, ready0;
   logic        err2, err0;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata2), .ready(ready2), .err(err2)
   );

   mem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) dutZero (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata0), .ready(ready0), .err(err0)
   );

   // Issues one request, drops req after acceptance, and reports the cycle count to ready.
   task automatic applyStimulus(input bit useZero, input logic w, input logic [31:0] a,
                                input logic [31:0] d, output int lat,
                                output logic [31:0] rd, output logic e);
      lat = -1;
      rd  = 32'd0;
      e   = 1'b0;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1 req = 1'b0;
      for (int k = 1; k <= 12 && lat < 0; k++) begin
         @(posedge clk);
         #1;
         if (useZero ? ready0 : ready2) begin
            lat = k;
            rd  = useZero ? rdata0 : rdata2;
            e   = useZero ? err0 : err2;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      nCompared++;
      if (ready2 !== 1'b0 || err2 !== 1'b0 || rdata2 !== 32'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_lat2: ready=%b err=%b rdata=%h expected 0/0/0", ready2, err2, rdata2);
      end
      nCompared++;
      if (ready0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_lat0: ready=%b err=%b rdata=%h expected 0/0/0", ready0, err0, rdata0);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic e;
      applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e);
      nCompared++;
      if (lat !== 3 || e !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL wr_0x10: lat=%0d err=%b expected lat=3 err=0", lat, e);
      end
      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, e);
      nCompared++;
      if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
         nMismatched++;
         $display("[TB] FAIL rd_0x10: lat=%0d err=%b rdata=%h expected 3/0/deadbeef", lat, e, rd);
      end
   endtask

   task automatic test_misaligned();
      int lat; logic [31:0] rd; logic e;
      applyStimulus(1'b0, 1'b1, 32'h13, 32'h12345678, lat, rd, e);
      nCompared++;
      if (lat !== 3 || e !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL misaligned_wr: lat=%0d err=%b expected lat=3 err=1", lat, e);
      end
      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, e);
      nCompared++;
      if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
         nMismatched++;
         $display("[TB] FAIL misaligned_keep: lat=%0d err=%b rdata=%h expected 3/0/deadbeef", lat, e, rd);
      end
   endtask

   task automatic test_out_of_range();
      int lat; logic [31:0] rd; logic e;
      applyStimulus(1'b0, 1'b0, 32'h400, 32'h0, lat, rd, e);
      nCompared++;
      if (lat !== 3 || e !== 1'b1 || rd !== 32'd0) begin
         nMismatched++;
         $display("[TB] FAIL oor_rd: lat=%0d err=%b rdata=%h expected 3/1/00000000", lat, e, rd);
      end
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000AAAA, lat, rd, e);
      applyStimulus(1'b0, 1'b1, 32'h400, 32'hBADBAD00, lat, rd, e);
      nCompared++;
      if (e !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL oor_wr_err: err=%b expected 1", e);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, e);
      nCompared++;
      if (e !== 1'b0 || rd !== 32'h0000AAAA) begin
         nMismatched++;
         $display("[TB] FAIL oor_no_wrap: err=%b rdata=%h expected 0/0000aaaa", e, rd);
      end
      applyStimulus(1'b0, 1'b1, 32'h3FC, 32'hA5A50FF0, lat, rd, e);
      applyStimulus(1'b0, 1'b0, 32'h3FC, 32'h0, lat, rd, e);
      nCompared++;
      if (lat !== 3 || e !== 1'b0 || rd !== 32'hA5A50FF0) begin
         nMismatched++;
         $display("[TB] FAIL top_word: lat=%0d err=%b rdata=%h expected 3/0/a5a50ff0", lat, e, rd);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] rd; logic e;
      logic [31:0] expData [3];
      int hit;
      expData[0] = 32'h0000AAAA; expData[1] = 32'h44444444; expData[2] = 32'h88888888;
      applyStimulus(1'b0, 1'b1, 32'h4, 32'h44444444, lat, rd, e);
      applyStimulus(1'b0, 1'b1, 32'h8, 32'h88888888, lat, rd, e);
      hit = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h0;
      @(posedge clk);
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk);
         #1;
         nCompared++;
         if (ready2 !== ((k % 4) == 3 && k <= 11)) begin
            nMismatched++;
            $display("[TB] FAIL b2b_ready_k%0d: ready=%b expected %b", k, ready2, ((k % 4) == 3 && k <= 11));
         end
         if (ready2 === 1'b1 && hit < 3) begin
            nCompared++;
            if (rdata2 !== expData[hit]) begin
               nMismatched++;
               $display("[TB] FAIL b2b_data%0d: rdata=%h expected %h", hit, rdata2, expData[hit]);
            end
            hit++;
            addr = 32'(hit * 4);
            if (hit == 3) req = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      int lat; logic [31:0] rd; logic e;
      applyStimulus(1'b0, 1'b1, 32'h20, 32'h11111111, lat, rd, e);
      applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, lat, rd, e);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 req = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      nCompared++;
      if (ready2 !== 1'b0 || err2 !== 1'b0 || rdata2 !== 32'd0) begin
         nMismatched++;
         $display("[TB] FAIL midop_reset: ready=%b err=%b rdata=%h expected 0/0/0", ready2, err2, rdata2);
      end
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         nCompared++;
         if (ready2 !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midop_noready_k%0d: ready=%b expected 0", k, ready2);
         end
      end
      applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, lat, rd, e);
      nCompared++;
      if (lat !== 3 || rd !== 32'h11111111) begin
         nMismatched++;
         $display("[TB] FAIL midop_old_value: lat=%0d rdata=%h expected 3/11111111", lat, rd);
      end
   endtask

   task automatic test_zero_latency();
      int lat; logic [31:0] rd; logic e;
      applyStimulus(1'b1, 1'b1, 32'h8, 32'h600DF00D, lat, rd, e);
      nCompared++;
      if (lat !== 1 || e !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL lat0_wr: lat=%0d err=%b expected 1/0", lat, e);
      end
      applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, lat, rd, e);
      nCompared++;
      if (lat !== 1 || rd !== 32'h600DF00D) begin
         nMismatched++;
         $display("[TB] FAIL lat0_rd: lat=%0d rdata=%h expected 1/600df00d", lat, rd);
      end
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h8;
      @(posedge clk);
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         nCompared++;
         if (ready0 !== ((k % 2) == 1 && k <= 5)) begin
            nMismatched++;
            $display("[TB] FAIL lat0_b2b_k%0d: ready=%b expected %b", k, ready0, ((k % 2) == 1 && k <= 5));
         end
         if (k == 5) req = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_misaligned();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_op();
      test_zero_latency();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
